// File: rtl/uart_result_tx_ctrl.sv
`timescale 1ns/1ps
// uart_result_tx_ctrl: sends each latched ALU result to the host as ASCII
// decimal text followed by CR/LF. It runs one conversion on the shared
// binary-to-BCD converter, then feeds the UART transmitter one byte at a time.
// Optional build macro TX_LZ_SUPPRESS_EN: leading zero digits are not sent
// (digit 0 is always sent). Without it, every message is DIGITS+2 bytes.
module uart_result_tx_ctrl #(
  parameter int unsigned N      = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic          clock,
  input  logic          CPU_RESETN,
  input  logic          trigger,
  input  logic [N-1:0]  result,
  output logic          bcd_trigger,
  output logic [31:0]   bcd_in,
  input  logic          bcd_idle,
  input  logic [31:0]   bcd,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic          busy,
  output logic          done
);

  typedef enum logic [3:0] {
    IDLE,
    CONV_START,
    CONV_RUN,
    CONV_DONE,
    TX_LOAD,
    TX_REQ,
    TX_ACK,
    TX_WAIT,
    TX_NEXT
  } state_t;

  // Byte position counts down: DIGITS+1..2 select digit (pos-2), 1 is CR, 0 is LF.
  localparam logic [3:0] POS_TOP = 4'(DIGITS + 1);

  state_t              state;
  logic [4*DIGITS-1:0] digits_q;
  logic [3:0]          pos_q;
  logic [3:0]          start_pos;

  // Converter digits above DIGITS are never transmitted.
  if (DIGITS < 8) begin : g_bcd_hi
    logic unused_bcd_hi;
    assign unused_bcd_hi = ^bcd[31:4*DIGITS];
  end

  // ASCII byte for a message position: digit, '?' for a non-decimal nibble, CR or LF.
  function automatic logic [7:0] byte_at(input logic [3:0] pos,
                                         input logic [4*DIGITS-1:0] dg);
    logic [7:0] b;
    logic [3:0] d;
    d = 4'(dg >> (4 * (32'(pos) - 32'd2)));
    if (pos == 4'd0)      b = 8'h0A;
    else if (pos == 4'd1) b = 8'h0D;
    else if (d > 4'd9)    b = 8'h3F;
    else                  b = 8'h30 + {4'h0, d};
    return b;
  endfunction

`ifdef TX_LZ_SUPPRESS_EN
  // First position to send: the most significant nonzero digit, else digit 0.
  always_comb begin
    start_pos = 4'd2;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) start_pos = 4'(i + 2);
    end
  end
`else
  // First position to send: always the top digit (zero-padded message).
  always_comb begin
    start_pos = POS_TOP;
  end
`endif

  // Sequencer: accept a result, run the converter, then stream digits and CR/LF.
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state       <= IDLE;
      bcd_trigger <= 1'b0;
      bcd_in      <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      digits_q    <= '0;
      pos_q       <= '0;
    end else begin
      bcd_trigger <= 1'b0;
      tx_start    <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          // done is still high in the first IDLE cycle; a trigger then is dropped.
          if (trigger && !done) begin
            bcd_in <= 32'(result);
            busy   <= 1'b1;
            state  <= CONV_START;
          end
        end
        CONV_START: begin
          bcd_trigger <= 1'b1;
          state       <= CONV_RUN;
        end
        CONV_RUN: begin
          if (!bcd_idle) state <= CONV_DONE;
        end
        CONV_DONE: begin
          if (bcd_idle) begin
            digits_q <= bcd[4*DIGITS-1:0];
            pos_q    <= start_pos;
            state    <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          tx_data <= byte_at(pos_q, digits_q);
          state   <= TX_REQ;
        end
        TX_REQ: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= TX_ACK;
          end
        end
        TX_ACK: begin
          if (tx_busy) state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!tx_busy) state <= TX_NEXT;
        end
        TX_NEXT: begin
          if (pos_q == 4'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // Next byte is loaded here directly, so TX_LOAD only serves the first
            // byte; this keeps the busy-low to next tx_start gap at two cycles.
            pos_q   <= pos_q - 4'd1;
            tx_data <= byte_at(pos_q - 4'd1, digits_q);
            state   <= TX_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_tx_ctrl.sv
`timescale 1ns/1ps
// Bench for uart_result_tx_ctrl with a behavioural converter and transmitter.
module tb_uart_result_tx_ctrl;
  localparam int unsigned N      = 16;
  localparam int unsigned DIGITS = 5;

  logic         clock;
  logic         CPU_RESETN;
  logic         trigger;
  logic [N-1:0] result;
  logic         bcd_trigger;
  logic [31:0]  bcd_in;
  logic         bcd_idle;
  logic [31:0]  bcd;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic         busy;
  logic         done;

  uart_result_tx_ctrl #(.N(N), .DIGITS(DIGITS)) dut (
    .clock(clock), .CPU_RESETN(CPU_RESETN), .trigger(trigger), .result(result),
    .bcd_trigger(bcd_trigger), .bcd_in(bcd_in), .bcd_idle(bcd_idle), .bcd(bcd),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .done(done)
  );

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          bt_cnt = 0;
  int unsigned bt_cyc = 0;
  int unsigned conv_done_cyc = 0;
  int unsigned trig_cyc = 0;
  int          done_cnt = 0;
  int          done_busy_bad = 0;
  int          unstable = 0;
  int          bad_start = 0;
  logic [7:0]  rx_q[$];
  int unsigned start_q[$];
  int unsigned fall_q[$];
  logic [7:0]  exp_q[$];
  bit          tx_hold = 1'b0;
  int          tx_len_max = 6;
  int          corrupt_pos = -1;
  logic [3:0]  corrupt_val = 4'h0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    if (corrupt_pos >= 0) r[4*corrupt_pos +: 4] = corrupt_val;
    return r;
  endfunction

  // Converter model: goes busy after bcd_trigger, returns decimal digits later.
  initial begin : conv_model
    bcd_idle = 1'b1;
    bcd = '0;
    forever begin
      @(posedge clock); #1;
      if (bcd_trigger === 1'b1) begin
        bt_cnt++;
        bt_cyc = cyc;
        bcd_idle = 1'b0;
        bcd = $urandom;
        repeat ($urandom_range(6, 1)) @(posedge clock);
        #1;
        bcd = to_bcd(bcd_in);
        bcd_idle = 1'b1;
        conv_done_cyc = cyc;
      end
    end
  end

  // Transmitter model: captures each requested byte, stays busy a few cycles.
  initial begin : tx_model
    logic [7:0] b;
    int len;
    tx_busy = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (tx_hold) begin
        if (tx_start === 1'b1) bad_start++;
        tx_busy = 1'b1;
      end else if (tx_start === 1'b1 && tx_busy === 1'b0) begin
        b = tx_data;
        rx_q.push_back(b);
        start_q.push_back(cyc);
        tx_busy = 1'b1;
        len = $urandom_range(tx_len_max, 2);
        repeat (len) begin
          @(posedge clock); #1;
          if (CPU_RESETN === 1'b1) begin
            if (tx_start !== 1'b0) bad_start++;
            if (tx_data !== b) unstable++;
          end
        end
        tx_busy = 1'b0;
        fall_q.push_back(cyc);
      end else begin
        if (tx_start === 1'b1) bad_start++;
        tx_busy = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clock); #1;
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) done_busy_bad++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  // Expected message from the decimal value of r (plus any forced bad digit).
  function automatic void build_exp(input int unsigned r);
    int d[DIGITS];
    int top;
    int unsigned x;
    exp_q.delete();
    x = r;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d[i] = int'(x % 10);
      x = x / 10;
    end
    if (corrupt_pos >= 0) d[corrupt_pos] = int'(corrupt_val);
    top = int'(DIGITS) - 1;
`ifdef TX_LZ_SUPPRESS_EN
    top = 0;
    for (int i = 0; i < int'(DIGITS); i++) if (d[i] != 0) top = i;
`endif
    for (int i = top; i >= 0; i--) exp_q.push_back(d[i] > 9 ? 8'h3F : 8'(48 + d[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic fire(input int unsigned r);
    trigger = 1'b1;
    result = N'(r);
    trig_cyc = cyc;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    check({tag, "_idle_timeout"}, 64'(n < 200), 64'd1);
  endtask

  task automatic wait_done(input string tag, input bit poke);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    check({tag, "_done_timeout"}, 64'(n < 3000), 64'd1);
    if (poke) begin
      trigger = 1'b1;
      result = N'(999);
      tick(1);
      trigger = 1'b0;
    end
  endtask

  task automatic check_msg(input string tag, input int base, input bit lat);
    logic [7:0] got;
    check({tag, "_nbytes"}, 64'(rx_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), 64'(got), 64'(exp_q[i]));
      if (i > 0 && base + i < start_q.size())
        check($sformatf("%s_gap%0d", tag, i), 64'(start_q[base + i] - fall_q[base + i - 1]), 64'd3);
    end
    if (lat && base < start_q.size())
      check({tag, "_first_lat"}, 64'(start_q[base] - conv_done_cyc), 64'd3);
    check({tag, "_bcd_lat"}, 64'(bt_cyc - trig_cyc), 64'd2);
  endtask

  task automatic send(input string tag, input int unsigned r, input bit lat, input bit poke);
    int base, d0, b0;
    wait_idle(tag);
    build_exp(r);
    base = rx_q.size();
    d0 = done_cnt;
    b0 = bt_cnt;
    fire(r);
    wait_done(tag, poke);
    tick(3);
    check_msg(tag, base, lat);
    check({tag, "_dones"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_convs"}, 64'(bt_cnt - b0), 64'd1);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin : main
    int base, d0, b0, n, n0;
    CPU_RESETN = 1'b0;
    trigger = 1'b0;
    result = '0;
    tick(3);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_bcd_trigger", 64'(bcd_trigger), 64'd0);
    check("rst_bcd_in", 64'(bcd_in), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    CPU_RESETN = 1'b1;
    tick(2);

    send("r7", 7, 1'b1, 1'b0);
    send("r12345", 12345, 1'b1, 1'b0);
    send("r0_poke", 0, 1'b1, 1'b1);

    // Second trigger while the third byte is in flight must be ignored.
    wait_idle("dup");
    build_exp(65535);
    base = rx_q.size();
    d0 = done_cnt;
    b0 = bt_cnt;
    fire(65535);
    n = 0;
    while (rx_q.size() - base < 3 && n < 2000) begin
      tick(1);
      n++;
    end
    check("dup_third_timeout", 64'(n < 2000), 64'd1);
    check("dup_busy_mid", 64'(busy), 64'd1);
    trigger = 1'b1;
    result = N'(1);
    tick(1);
    trigger = 1'b0;
    wait_done("dup", 1'b0);
    tick(40);
    check_msg("dup", base, 1'b1);
    check("dup_dones", 64'(done_cnt - d0), 64'd1);
    check("dup_convs", 64'(bt_cnt - b0), 64'd1);
    check("dup_bcd_in", 64'(bcd_in), 64'd65535);

    // Transmitter held busy before the first byte.
    tx_hold = 1'b1;
    tick(2);
    wait_idle("hold");
    build_exp(321);
    base = rx_q.size();
    d0 = done_cnt;
    fire(321);
    tick(50);
    check("hold_no_start", 64'(rx_q.size() - base), 64'd0);
    check("hold_busy", 64'(busy), 64'd1);
    tx_hold = 1'b0;
    wait_done("hold", 1'b0);
    tick(3);
    check_msg("hold", base, 1'b0);
    check("hold_dones", 64'(done_cnt - d0), 64'd1);

    // Non-decimal nibbles from the converter become '?'.
    corrupt_pos = 2;
    corrupt_val = 4'hC;
    send("bad_mid", 12345, 1'b1, 1'b0);
    corrupt_pos = 4;
    corrupt_val = 4'hB;
    send("bad_top", 7, 1'b1, 1'b0);
    corrupt_pos = -1;

    for (int k = 0; k < 8; k++) begin
      tx_len_max = $urandom_range(12, 2);
      send($sformatf("rnd%0d", k), $urandom_range(65535, 0), 1'b1, 1'b0);
    end
    send("r65535", 65535, 1'b1, 1'b0);
    tx_len_max = 6;

    // Asynchronous reset in the middle of a message.
    wait_idle("rst_mid");
    base = rx_q.size();
    fire(54321);
    n = 0;
    while (rx_q.size() - base < 2 && n < 2000) begin
      tick(1);
      n++;
    end
    check("rst_mid_timeout", 64'(n < 2000), 64'd1);
    tick(1);
    #3;
    CPU_RESETN = 1'b0;
    #1;
    check("rst_mid_tx_start", 64'(tx_start), 64'd0);
    check("rst_mid_bcd_trigger", 64'(bcd_trigger), 64'd0);
    check("rst_mid_bcd_in", 64'(bcd_in), 64'd0);
    check("rst_mid_tx_data", 64'(tx_data), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    @(posedge clock); #1;
    tick(20);
    CPU_RESETN = 1'b1;
    n0 = rx_q.size();
    b0 = bt_cnt;
    tick(20);
    check("rst_no_resend", 64'(rx_q.size()), 64'(n0));
    check("rst_no_conv", 64'(bt_cnt), 64'(b0));
    check("rst_idle_busy", 64'(busy), 64'd0);
    send("r42", 42, 1'b1, 1'b0);

    check("tx_data_stable", 64'(unstable), 64'd0);
    check("tx_start_while_busy", 64'(bad_start), 64'd0);
    check("done_with_busy", 64'(done_busy_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
